// File: rtl/muldiv_iter_ctrl_if.sv
// Issue/writeback bundle between the execute stage and the iterative divider.
// The master side is EX (it issues ops), and the slave side is the divider.
interface muldiv_iter_ctrl_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic            op_div;
    logic            op_signed;
    logic            op_word;
    logic            kill;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [5:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [5:0]      rd_out;
    logic            ex_stall;

    modport master (
        output start, op_div, op_signed, op_word, kill, rs1, rs2, rd_in,
        input  busy, done, result, rd_out, ex_stall
    );

    modport slave (
        input  start, op_div, op_signed, op_word, kill, rs1, rs2, rd_in,
        output busy, done, result, rd_out, ex_stall
    );
endinterface

// File: rtl/muldiv_iter_ctrl.sv
// Sequencer and datapath for an iterative radix-2^BPC restoring divider.
// It covers the RISC-V div/divu/rem/remu operations and their W variants.
//
//  state   | meaning
//  --------+------------------------------------------------------------------
//  S_IDLE  | waiting for start; operands and tag are latched on issue
//  S_PREP  | extend and take magnitudes; short-circuit div-by-zero/overflow
//  S_ITER  | retire BPC quotient bits per cycle; counter counts down to 1
//  S_FIXUP | apply signs, select quotient/remainder, register the result
//  S_DONE  | one-cycle done pulse; EX advances with the result
module muldiv_iter_ctrl #(
    parameter int XLEN = 64,
    parameter int BPC  = 1
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_iter_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIXUP,
        S_DONE
    } state_t;

    localparam logic [XLEN:0] CNT_FULL = (XLEN+1)'(XLEN / BPC);
    localparam logic [XLEN:0] CNT_WORD = (XLEN+1)'(32 / BPC);

    state_t          state, state_nxt;

    logic            op_div_q, op_signed_q, op_word_q;
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic [5:0]      rd_q;
    logic            q_neg, r_neg;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] quo;
    logic [XLEN:0]   rem;
    logic [XLEN:0]   cnt;
    logic [XLEN-1:0] result_q;

    function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] v,
                                              input logic w, input logic s);
        return w ? {{(XLEN-32){s & v[31]}}, v[31:0]} : v;
    endfunction

    // Operand preparation, only consumed in S_PREP
    logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_neg, special_res;
    logic            sa, sb, div_zero, ovf, special;

    always_comb begin
        a_ext    = ext_w(rs1_q, op_word_q, op_signed_q);
        b_ext    = ext_w(rs2_q, op_word_q, op_signed_q);
        sa       = op_signed_q & a_ext[XLEN-1];
        sb       = op_signed_q & b_ext[XLEN-1];
        abs_a    = sa ? -a_ext : a_ext;
        abs_b    = sb ? -b_ext : b_ext;
        min_neg  = op_word_q ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        ovf      = op_signed_q & (a_ext == min_neg) & (b_ext == '1);
        special  = div_zero | ovf;
        if (op_div_q)
            special_res = div_zero ? '1 : a_ext;
        else
            special_res = div_zero ? a_ext : '0;
        special_res = ext_w(special_res, op_word_q, 1'b1);
    end

    // BPC restoring steps; the dividend is shifted out of the top of quo
    // while quotient bits enter at the bottom.
    logic [XLEN:0]   rem_i, rem_sh;
    logic [XLEN-1:0] quo_i;

    always_comb begin
        rem_i  = rem;
        quo_i  = quo;
        rem_sh = '0;
        for (int k = 0; k < BPC; k++) begin
            rem_sh = {rem_i[XLEN-1:0], quo_i[XLEN-1]};
            quo_i  = {quo_i[XLEN-2:0], 1'b0};
            if (rem_sh >= {1'b0, divisor}) begin
                rem_i    = rem_sh - {1'b0, divisor};
                quo_i[0] = 1'b1;
            end else begin
                rem_i = rem_sh;
            end
        end
    end

    logic [XLEN-1:0] fix_q, fix_r, fix_res;

    always_comb begin
        fix_q   = q_neg ? -quo : quo;
        fix_r   = r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        fix_res = ext_w(op_div_q ? fix_q : fix_r, op_word_q, 1'b1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start && !bus.kill) state_nxt = S_PREP;
            S_PREP:  if (bus.kill)               state_nxt = S_IDLE;
                     else if (special)           state_nxt = S_DONE;
                     else                        state_nxt = S_ITER;
            S_ITER:  if (bus.kill)               state_nxt = S_IDLE;
                     else if (cnt == 1)          state_nxt = S_FIXUP;
            S_FIXUP: if (bus.kill)               state_nxt = S_IDLE;
                     else                        state_nxt = S_DONE;
            S_DONE:                              state_nxt = S_IDLE;
            default:                             state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_div_q    <= 1'b0;
            op_signed_q <= 1'b0;
            op_word_q   <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            divisor     <= '0;
            quo         <= '0;
            rem         <= '0;
            cnt         <= '0;
            result_q    <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start && !bus.kill) begin
                    op_div_q    <= bus.op_div;
                    op_signed_q <= bus.op_signed;
                    op_word_q   <= bus.op_word;
                    rs1_q       <= bus.rs1;
                    rs2_q       <= bus.rs2;
                    rd_q        <= bus.rd_in;
                end
                S_PREP: begin
                    q_neg   <= sa ^ sb;
                    r_neg   <= sa;
                    divisor <= abs_b;
                    rem     <= '0;
                    quo     <= op_word_q ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
                    cnt     <= op_word_q ? CNT_WORD : CNT_FULL;
                    if (state_nxt == S_DONE)
                        result_q <= special_res;
                end
                S_ITER: begin
                    rem <= rem_i;
                    quo <= quo_i;
                    cnt <= cnt - 1'b1;
                end
                S_FIXUP: if (state_nxt == S_DONE) result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.result   = result_q;
    assign bus.rd_out   = rd_q;
    assign bus.ex_stall = ((state == S_IDLE) & bus.start & ~bus.kill)
                        | ((state != S_IDLE) & (state != S_DONE));
endmodule

// File: tb/tb_muldiv_iter_ctrl.sv
// Directed self-checking bench for muldiv_iter_ctrl (XLEN=64, BPC=1).
module tb_muldiv_iter_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    muldiv_iter_ctrl_if #(.XLEN(64)) bus ();

    muldiv_iter_ctrl #(.XLEN(64), .BPC(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.start     = 1'b0;
        bus.kill      = 1'b0;
        bus.op_div    = 1'b0;
        bus.op_signed = 1'b0;
        bus.op_word   = 1'b0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.rd_in     = '0;
    endtask

    // Issue one op at a negedge (cycle 0) and follow it to done.
    // pulse_cyc >= 1 re-asserts start with different operands mid-op.
    task automatic run_op(input string tag, input bit dv, input bit sg, input bit wd,
                          input logic [63:0] a, input logic [63:0] b, input logic [5:0] rd,
                          input logic [63:0] exp_res, input int exp_cyc, input int pulse_cyc);
        int          cyc;
        int          done_cyc;
        bit          stall_bad;
        logic        stall_at_done;
        logic [63:0] res;
        logic [5:0]  rdo;
        @(negedge clk);
        bus.start = 1'b1; bus.kill = 1'b0;
        bus.op_div = dv; bus.op_signed = sg; bus.op_word = wd;
        bus.rs1 = a; bus.rs2 = b; bus.rd_in = rd;
        #1 check({tag, "/stall_c0"}, 64'(bus.ex_stall), 64'd1);
        cyc = 0; done_cyc = -1; stall_bad = 1'b0;
        stall_at_done = 1'bx; res = 'x; rdo = 'x;
        while (done_cyc < 0 && cyc < 150) begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == pulse_cyc);
            if (cyc == pulse_cyc) begin
                bus.rs1 = 64'd999; bus.rs2 = 64'd1; bus.rd_in = ~rd; bus.op_div = ~dv;
            end
            #1;
            if (bus.done) begin
                done_cyc      = cyc;
                stall_at_done = bus.ex_stall;
                res           = bus.result;
                rdo           = bus.rd_out;
            end else if (!bus.ex_stall || !bus.busy) begin
                stall_bad = 1'b1;
            end
        end
        bus.start = 1'b0;
        check({tag, "/done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
        check({tag, "/result"}, res, exp_res);
        check({tag, "/rd_out"}, 64'(rdo), 64'(rd));
        check({tag, "/stall_while_busy"}, 64'(stall_bad), 64'd0);
        check({tag, "/stall_at_done"}, 64'(stall_at_done), 64'd0);
        @(negedge clk);
        #1 check({tag, "/idle_after"}, {62'd0, bus.done, bus.busy}, 64'd0);
        check({tag, "/result_hold"}, bus.result, exp_res);
    endtask

    task automatic watch_no_done(input string tag, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1 if (bus.done || bus.busy) seen = 1'b1;
        end
        check({tag, "/no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        check("reset/flags", {61'd0, bus.busy, bus.done, bus.ex_stall}, 64'd0);
        check("reset/result", bus.result, 64'd0);
        check("reset/rd_out", 64'(bus.rd_out), 64'd0);
        reset = 1'b0;

        run_op("divu_100_7",   1, 0, 0, 64'd100, 64'd7, 6'd5, 64'd14, 67, -1);
        run_op("rem_m7_2",     0, 1, 0, -64'sd7, 64'd2, 6'd6, 64'hFFFF_FFFF_FFFF_FFFF, 67, -1);
        run_op("div_m7_2",     1, 1, 0, -64'sd7, 64'd2, 6'd7, 64'hFFFF_FFFF_FFFF_FFFD, 67, -1);
        run_op("div_7_m2",     1, 1, 0, 64'd7, -64'sd2, 6'd8, 64'hFFFF_FFFF_FFFF_FFFD, 67, -1);
        run_op("rem_7_m2",     0, 1, 0, 64'd7, -64'sd2, 6'd9, 64'd1, 67, -1);
        run_op("divu_max_16",  1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 6'd10,
               64'h0FFF_FFFF_FFFF_FFFF, 67, -1);
        run_op("div_5_0",      1, 1, 0, 64'd5, 64'd0, 6'd11, 64'hFFFF_FFFF_FFFF_FFFF, 2, -1);
        run_op("remu_5_0",     0, 0, 0, 64'd5, 64'd0, 6'd12, 64'd5, 2, -1);
        run_op("div_ovf",      1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd13,
               64'h8000_0000_0000_0000, 2, -1);
        run_op("rem_ovf",      0, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd14,
               64'd0, 2, -1);
        run_op("divw_m7_2",    1, 1, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 6'd15,
               64'hFFFF_FFFF_FFFF_FFFD, 35, -1);
        run_op("divuw_sext",   1, 0, 1, 64'h0000_0000_8000_0000, 64'd1, 6'd16,
               64'hFFFF_FFFF_8000_0000, 35, -1);
        run_op("remuw_hi_ign", 0, 0, 1, 64'h1234_5678_0000_0011, 64'hFFFF_FFFF_0000_0005, 6'd17,
               64'd2, 35, -1);
        run_op("divw_ovf",     1, 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 6'd18,
               64'hFFFF_FFFF_8000_0000, 2, -1);
        run_op("divu_pulse",   1, 0, 0, 64'd100, 64'd7, 6'd19, 64'd14, 67, 5);

        // start together with kill is dropped
        @(negedge clk);
        bus.start = 1'b1; bus.kill = 1'b1; bus.op_div = 1'b1; bus.rs1 = 64'd9; bus.rs2 = 64'd3;
        #1 check("start_kill/stall", 64'(bus.ex_stall), 64'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.kill = 1'b0;
        #1 check("start_kill/busy", 64'(bus.busy), 64'd0);

        // kill in ITER cycle 10
        @(negedge clk);
        bus.start = 1'b1; bus.op_div = 1'b1; bus.op_signed = 1'b0; bus.op_word = 1'b0;
        bus.rs1 = 64'd100; bus.rs2 = 64'd7; bus.rd_in = 6'd33;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.kill  = (c == 10);
        end
        #1 check("kill/stall_c10", 64'(bus.ex_stall), 64'd1);
        @(negedge clk);
        bus.kill = 1'b0;
        #1 check("kill/flags_c11", {62'd0, bus.busy, bus.ex_stall}, 64'd0);
        check("kill/result_kept", bus.result, 64'd14);
        watch_no_done("kill", 80);

        // reset in cycle 20
        @(negedge clk);
        bus.start = 1'b1; bus.rs1 = 64'd1000; bus.rs2 = 64'd3; bus.rd_in = 6'd44;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            reset     = (c == 20);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid/flags", {61'd0, bus.busy, bus.done, bus.ex_stall}, 64'd0);
        check("rst_mid/result", bus.result, 64'd0);
        check("rst_mid/rd_out", 64'(bus.rd_out), 64'd0);
        watch_no_done("rst_mid", 80);

        run_op("divu_after_rst", 1, 0, 0, 64'd1000, 64'd3, 6'd45, 64'd333, 67, -1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
